// File: rtl/mdu_pipelined.sv
// Multiply/divide unit owning HI/LO: multi-cycle MULT(U) with a fixed latency, radix-2 restoring DIV(U),
// and single-cycle MTHI/MTLO writes. Busy stalls the core; flush aborts whatever is in flight.
module mdu_pipelined #(
  parameter int XLEN = 32,
  parameter int MUL_LAT = 3,
  parameter logic [XLEN-1:0] DIV_ZERO_LO = '1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  localparam int CW = $clog2(XLEN + MUL_LAT) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            sgn_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] quo, rem;

  logic [XLEN-1:0] dvs;
  logic [XLEN:0]   shifted, trial;
  logic            q_neg, r_neg;

  function automatic logic [2*XLEN-1:0] mul_full(input logic s, input logic [XLEN-1:0] x,
                                                 input logic [XLEN-1:0] y);
    logic [2*XLEN-1:0] xe, ye;
    xe = {{XLEN{s & x[XLEN-1]}}, x};
    ye = {{XLEN{s & y[XLEN-1]}}, y};
    return xe * ye;
  endfunction

  // Divider works on magnitudes; signs are restored in FIX from the latched raw operands.
  always_comb begin
    dvs     = (sgn_q && b_q[XLEN-1]) ? -b_q : b_q;
    shifted = {rem, quo[XLEN-1]};
    trial   = shifted - {1'b0, dvs};
    q_neg   = sgn_q & (a_q[XLEN-1] ^ b_q[XLEN-1]);
    r_neg   = sgn_q & a_q[XLEN-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      sgn_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      quo   <= '0;
      rem   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            a_q   <= a;
            b_q   <= b;
            sgn_q <= ~op[0];
            case (op)
              3'd0, 3'd1: begin
                if (MUL_LAT == 1) begin
                  {hi, lo} <= mul_full(~op[0], a, b);
                  done     <= 1'b1;
                end else begin
                  state <= MUL;
                  busy  <= 1'b1;
                  cnt   <= CW'(MUL_LAT - 2);
                end
              end
              3'd2, 3'd3: begin
                state <= DIV;
                busy  <= 1'b1;
                cnt   <= CW'(XLEN - 1);
                rem   <= '0;
                quo   <= (~op[0] && a[XLEN-1]) ? -a : a;
              end
              3'd4:    hi <= a;
              3'd5:    lo <= a;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == '0) begin
            {hi, lo} <= mul_full(sgn_q, a_q, b_q);
            done     <= 1'b1;
            state    <= IDLE;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIV: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            // A non-negative trial difference means the divisor fits: keep it and shift in a 1.
            if (!trial[XLEN]) begin
              rem <= trial[XLEN-1:0];
              quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
              rem <= shifted[XLEN-1:0];
              quo <= {quo[XLEN-2:0], 1'b0};
            end
            if (cnt == '0) state <= FIX;
            else           cnt   <= cnt - 1'b1;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            done <= 1'b1;
            if (b_q == '0) begin
              lo <= DIV_ZERO_LO;
              hi <= a_q;
            end else begin
              lo <= q_neg ? -quo : quo;
              hi <= r_neg ? -rem : rem;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/mdu_pipelined.md
Name: mdu_pipelined

Overview:
- Parametrised multiply/divide unit for the MIPS pipelined core; executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Owns the architectural HI/LO registers.
- Sits beside the EX-stage ALU. Operands come from the ID/EX register outputs; hi/lo feed the EX result mux for MFHI/MFLO.
- The core stalls on busy; the unit supports flush on branch squash.

Parameters:
- XLEN, 32, operand/result width; must be even and >= 8.
- MUL_LAT, 3, multiply latency in cycles from accept to result; >= 1.
- DIV_ZERO_LO, all-ones, LO value written on divide-by-zero (HI gets dividend).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request valid for one cycle; accepted only when busy==0.
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved (accepted, no effect, no done).
- a  in  XLEN  rs operand (dividend / multiplicand / MTHI/MTLO source).
- b  in  XLEN  rt operand (divisor / multiplier).
- flush  in  1  abort in-flight mult/div.
- busy  out  1  operation in flight; core must stall MFHI/MFLO and new MDU ops.
- done  out  1  one-cycle pulse when HI/LO committed by mult/div.
- hi  out  XLEN  architectural HI.
- lo  out  XLEN  architectural LO.

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, state=IDLE, divider counter=0. Reset mid-operation discards the operation with no HI/LO write.
- FSM states:
  - IDLE: start accepted here only.
  - MUL: counts MUL_LAT-1 cycles.
  - DIV: one radix-2 restoring step per cycle, XLEN cycles.
  - FIX: sign correction, 1 cycle.
  - Back to IDLE.
- Accept: start in cycle T with busy==0 latches op, a and b. start while busy==1 is ignored, with no side effect.
- MTHI/MTLO: hi (resp. lo) <= a at the end of cycle T. busy stays 0, no done. The new value is visible in cycle T+1.
- MULT/MULTU timing:
  - busy=1 in cycles T+1..T+MUL_LAT-1.
  - {hi,lo} <= 2*XLEN-bit product at the edge ending cycle T+MUL_LAT-1.
  - In cycle T+MUL_LAT: done=1, busy=0, new hi/lo visible.
  - With MUL_LAT=1: busy never rises and done is in T+1.
  - MULT is signed×signed; MULTU is unsigned.
- DIV/DIVU timing:
  - busy=1 in cycles T+1..T+XLEN+1.
  - done=1 and results visible in cycle T+XLEN+2.
  - Latency is fixed and independent of operand values.
- DIV signed semantics: magnitudes are divided. The quotient is negated if the signs differ; the remainder takes the dividend's sign. Quotient goes to LO, remainder to HI.
- Divide-by-zero (b==0), both ops: same latency, lo=DIV_ZERO_LO, hi=a.
- Signed overflow: DIV with a=most-negative and b=-1 gives lo=most-negative, hi=0.
- Back-to-back: start is accepted in the done cycle (busy==0 there), so issue every MUL_LAT cycles is sustained.
- flush:
  - With busy==1, or coincident with start: the operation is aborted at that edge. hi/lo are unchanged and no done is produced. busy=0 and state=IDLE the next cycle.
  - flush with start for MTHI/MTLO suppresses the write.
  - flush in IDLE without start: no effect.
  - flush in the done cycle: the commit has already happened; no effect.
- done is never asserted for MTHI/MTLO, reserved ops, or flushed ops.
- hi/lo change only on a commit, MTHI/MTLO, or reset.
- Simultaneous reset and flush/start: reset wins.

Test Plan:
- Reset, then MTHI a=0x12345678 and MTLO a=0x9ABCDEF0 in consecutive cycles -> hi=0x12345678, lo=0x9ABCDEF0, busy and done never high.
- MULT a=0xFFFFFFFF (-1), b=0x00000002, MUL_LAT=3, start at T -> busy high T+1..T+2; done at T+3 with hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9), b=2 -> done at T+34 (XLEN=32), lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=7, b=2 -> lo=3, hi=1.
- DIVU a=0x55, b=0 -> done at T+34, lo=0xFFFFFFFF, hi=0x55. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV started, flush at T+10, start MULT 3×4 at T+10 -> DIV aborted and MULT not accepted (flush wins), hi/lo unchanged, busy=0 at T+11, no done. Re-issue MULT at T+11 -> done at T+14, lo=12, hi=0.
- Back-to-back MULTs issued in each done cycle, plus a start asserted while busy -> every result commits in order, the extra start is ignored, and exactly one done pulse occurs per accepted op.
